// File: rtl/pec_pkg.sv
// Shared constants for the parameterised event counter: parameter defaults,
// legal parameter ranges, direction encoding and a sizing helper.
package pec_pkg;

    localparam int WIDTH_DEF    = 16;
    localparam int WIDTH_MIN    = 2;
    localparam int WIDTH_MAX    = 32;

    localparam int NCH_DEF      = 4;
    localparam int NCH_MIN      = 1;
    localparam int NCH_MAX      = 8;

    localparam int TICK_DIV_DEF = 4;
    localparam int TICK_DIV_MIN = 1;
    localparam int TICK_DIV_MAX = 1024;

    // Encoding of each dir_up bit
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Bits needed for a counter that runs 0 .. div-1 (at least one bit)
    function automatic int tick_cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Count-enable generator: tick is high for one cycle out of every TICK_DIV.
// The phase counter restarts on rst so the first tick lands TICK_DIV cycles
// after reset is released.
module tick_divider
    import pec_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int            CW   = tick_cnt_width(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] cnt_q;

    // The tick is the last phase of the period; with TICK_DIV=1 the counter
    // sits at zero and every cycle is a tick.
    assign tick = (cnt_q == LAST);

    // Phase counter: 0 .. TICK_DIV-1, restarted by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + ONE;
        end
    end

endmodule

// File: rtl/param_event_counter.sv
// Multi-channel up/down event counter. Each channel steps on a shared tick
// when its event level is high, wraps or saturates at the unsigned limits,
// pulses tc_pulse when a limit is reached or crossed and keeps a sticky
// limit_flag. A masked load overrides a coincident step.
module param_event_counter
    import pec_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int NCH      = NCH_DEF,
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       evt_in,
    input  logic [NCH-1:0]       dir_up,
    input  logic                 sat_mode,
    input  logic                 load,
    input  logic [NCH-1:0]       load_mask,
    input  logic [WIDTH-1:0]     load_val,
    input  logic                 clr_flags,
    output logic [NCH*WIDTH-1:0] count_out,
    output logic [NCH-1:0]       tc_pulse,
    output logic [NCH-1:0]       limit_flag
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX ||
        NCH < NCH_MIN || NCH > NCH_MAX ||
        TICK_DIV < TICK_DIV_MIN || TICK_DIV > TICK_DIV_MAX) begin : g_param_check
        $error("param_event_counter: parameter out of range");
    end

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic tick;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] cnt_next;
        logic             tc_q;
        logic             tc_next;
        logic             flag_q;
        logic             step;

        assign step = tick & evt_in[k];

        // Next count and limit pulse: load wins, then a qualified step that
        // wraps or clamps at the limits depending on sat_mode.
        always_comb begin
            cnt_next = cnt_q;
            tc_next  = 1'b0;
            if (load && load_mask[k]) begin
                cnt_next = load_val;
            end else if (step) begin
                if (dir_up[k] == DIR_UP) begin
                    if (cnt_q == ALL_ONES) begin
                        tc_next = 1'b1;
                        if (!sat_mode) cnt_next = '0;
                    end else begin
                        cnt_next = cnt_q + ONE;
                        tc_next  = sat_mode && (cnt_q == ALL_ONES - ONE);
                    end
                end else begin
                    if (cnt_q == '0) begin
                        tc_next = 1'b1;
                        if (!sat_mode) cnt_next = ALL_ONES;
                    end else begin
                        cnt_next = cnt_q - ONE;
                        tc_next  = sat_mode && (cnt_q == ONE);
                    end
                end
            end
        end

        // Channel state; a new limit event beats a coincident flag clear
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q  <= '0;
                tc_q   <= 1'b0;
                flag_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_next;
                tc_q   <= tc_next;
                flag_q <= tc_next | (flag_q & ~clr_flags);
            end
        end

        assign count_out[k*WIDTH +: WIDTH] = cnt_q;
        assign tc_pulse[k]                 = tc_q;
        assign limit_flag[k]               = flag_q;
    end

endmodule

// File: tb/tb_param_event_counter.sv
// Directed bench for param_event_counter with a cycle-level reference model
// and literal checkpoints for the headline scenarios.
module tb_param_event_counter;

    localparam int WIDTH    = 16;
    localparam int NCH      = 4;
    localparam int TICK_DIV = 4;
    localparam int EW       = NCH*WIDTH + 2*NCH;
    localparam longint MAXV = (64'd1 << WIDTH) - 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst = 1'b1;
    logic [NCH-1:0]       evt_in = '0;
    logic [NCH-1:0]       dir_up = '0;
    logic                 sat_mode = 1'b0;
    logic                 load = 1'b0;
    logic [NCH-1:0]       load_mask = '0;
    logic [WIDTH-1:0]     load_val = '0;
    logic                 clr_flags = 1'b0;
    logic [NCH*WIDTH-1:0] count_out;
    logic [NCH-1:0]       tc_pulse;
    logic [NCH-1:0]       limit_flag;

    param_event_counter #(
        .WIDTH    (WIDTH),
        .NCH      (NCH),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .evt_in     (evt_in),
        .dir_up     (dir_up),
        .sat_mode   (sat_mode),
        .load       (load),
        .load_mask  (load_mask),
        .load_val   (load_val),
        .clr_flags  (clr_flags),
        .count_out  (count_out),
        .tc_pulse   (tc_pulse),
        .limit_flag (limit_flag)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] chan(input int k);
        return count_out[k*WIDTH +: WIDTH];
    endfunction

    // ---------------- reference model + scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    longint m_cnt [NCH];
    bit     m_tc  [NCH];
    bit     m_flag[NCH];
    int     since_rst = 0;
    bit     seen_rst  = 0;

    // Counts are plain integers: a step adds +/-1, then the result is either
    // clamped into [0, MAXV] or reduced modulo 2**WIDTH. A limit event is an
    // out-of-range raw result, or in saturate mode a raw result at a limit.
    always @(posedge clk) begin
        logic [EW-1:0] e;
        bit tick;
        longint raw;
        if (rst) begin
            seen_rst  = 1;
            since_rst = 0;
            for (int k = 0; k < NCH; k++) begin
                m_cnt[k] = 0; m_tc[k] = 0; m_flag[k] = 0;
            end
        end else if (seen_rst) begin
            since_rst++;
            tick = (since_rst % TICK_DIV) == 0;
            for (int k = 0; k < NCH; k++) begin
                bit tcn;
                tcn = 0;
                if (load && load_mask[k]) begin
                    m_cnt[k] = longint'(load_val);
                end else if (tick && evt_in[k]) begin
                    raw = m_cnt[k] + (dir_up[k] ? 1 : -1);
                    if (sat_mode) begin
                        m_cnt[k] = (raw > MAXV) ? MAXV : (raw < 0) ? 0 : raw;
                        tcn = dir_up[k] ? (raw >= MAXV) : (raw <= 0);
                    end else begin
                        m_cnt[k] = (raw + MAXV + 1) % (MAXV + 1);
                        tcn = (raw > MAXV) || (raw < 0);
                    end
                end
                m_flag[k] = tcn || (m_flag[k] && !clr_flags);
                m_tc[k]   = tcn;
            end
        end
        if (seen_rst) begin
            e = '0;
            for (int k = 0; k < NCH; k++) begin
                e[k*WIDTH +: WIDTH]     = WIDTH'(m_cnt[k]);
                e[NCH*WIDTH + k]        = m_tc[k];
                e[NCH*WIDTH + NCH + k]  = m_flag[k];
            end
            exp_q.push_back(e);
        end
    end

    // Compare every cycle once the model has an expectation
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("model count_out",  64'(count_out),  64'(e[NCH*WIDTH-1:0]));
            check("model tc_pulse",   64'(tc_pulse),   64'(e[NCH*WIDTH +: NCH]));
            check("model limit_flag", 64'(limit_flag), 64'(e[NCH*WIDTH+NCH +: NCH]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_idle();
        evt_in = '0; dir_up = '0; sat_mode = 1'b0;
        load = 1'b0; load_mask = '0; load_val = '0; clr_flags = 1'b0;
    endtask

    // Leaves rst low right after a negedge; the next posedge is edge 1 and
    // ticks fall on edges 4, 8, ...
    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    typedef struct {
        logic [NCH-1:0]   evt;
        logic [NCH-1:0]   dir;
        logic             sat;
        logic [NCH-1:0]   mask;
        logic [WIDTH-1:0] val;
        logic             clr;
        int               cycles;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{4'hF, 4'h5, 1'b0, 4'hA, 16'h0001, 1'b0, 9};
        vecs[1] = '{4'hF, 4'hA, 1'b1, 4'hF, 16'hFFFE, 1'b0, 9};
        vecs[2] = '{4'h6, 4'hF, 1'b0, 4'h0, 16'h0000, 1'b1, 8};
        vecs[3] = '{4'hF, 4'h0, 1'b1, 4'hF, 16'h0001, 1'b0, 9};
        vecs[4] = '{4'h9, 4'h9, 1'b0, 4'h9, 16'hFFFF, 1'b0, 5};
        vecs[5] = '{4'hF, 4'hF, 1'b1, 4'h3, 16'hFFFF, 1'b1, 6};

        set_idle();
        do_reset();
        check("reset count_out", 64'(count_out), 64'h0);
        check("reset tc_pulse", 64'(tc_pulse), 64'h0);
        check("reset limit_flag", 64'(limit_flag), 64'h0);

        // 40 cycles of up-counting on ch0 -> ten ticks
        evt_in = 4'b0001; dir_up = 4'b0001;
        cyc(40);
        check("ch0 after 40 cycles", 64'(chan(0)), 64'd10);
        check("others after 40 cycles", 64'(count_out[NCH*WIDTH-1:WIDTH]), 64'h0);

        // Wrap: ch1 at all-ones steps up to 0
        set_idle();
        do_reset();
        load = 1'b1; load_mask = 4'b0010; load_val = 16'hFFFF;
        cyc(1);
        load = 1'b0; evt_in = 4'b0010; dir_up = 4'b0010;
        cyc(3);
        check("wrap ch1", 64'(chan(1)), 64'h0);
        check("wrap tc_pulse", 64'(tc_pulse), 64'b0010);
        check("wrap limit_flag", 64'(limit_flag), 64'b0010);
        evt_in = '0;
        cyc(1);
        check("wrap tc one cycle", 64'(tc_pulse), 64'h0);
        check("wrap flag sticky", 64'(limit_flag), 64'b0010);

        // Saturate: ch2 down at 0 holds; ch0 up lands on all-ones then holds
        set_idle();
        do_reset();
        sat_mode = 1'b1;
        load = 1'b1; load_mask = 4'b0001; load_val = 16'hFFFE;
        evt_in = 4'b0101; dir_up = 4'b0001;
        cyc(1);
        load = 1'b0;
        cyc(3);
        check("sat ch2 hold 0", 64'(chan(2)), 64'h0);
        check("sat ch0 land max", 64'(chan(0)), 64'hFFFF);
        check("sat first pulses", 64'(tc_pulse), 64'b0101);
        cyc(1);
        check("sat pulse drops", 64'(tc_pulse), 64'h0);
        cyc(3);
        check("sat repeat pulses", 64'(tc_pulse), 64'b0101);
        check("sat ch0 held max", 64'(chan(0)), 64'hFFFF);
        check("sat ch2 held 0", 64'(chan(2)), 64'h0);

        // Load coincident with a tick: masked channels load, others step
        set_idle();
        do_reset();
        evt_in = 4'hF; dir_up = 4'hF;
        cyc(3);
        load = 1'b1; load_mask = 4'b0101; load_val = 16'h1234;
        cyc(1);
        load = 1'b0;
        check("load ch0", 64'(chan(0)), 64'h1234);
        check("load ch1 step", 64'(chan(1)), 64'h1);
        check("load ch2", 64'(chan(2)), 64'h1234);
        check("load ch3 step", 64'(chan(3)), 64'h1);
        check("load no tc", 64'(tc_pulse), 64'h0);

        // Set beats clear on ch3
        set_idle();
        do_reset();
        load = 1'b1; load_mask = 4'b1000; load_val = 16'hFFFF;
        cyc(1);
        load = 1'b0; evt_in = 4'b1000; dir_up = 4'b1000;
        cyc(2);
        clr_flags = 1'b1;
        cyc(1);
        clr_flags = 1'b0; evt_in = '0;
        check("set beats clear tc", 64'(tc_pulse), 64'b1000);
        check("set beats clear flag", 64'(limit_flag), 64'b1000);
        clr_flags = 1'b1;
        cyc(1);
        clr_flags = 1'b0;
        check("clear flag", 64'(limit_flag), 64'h0);

        // Reset with nonzero counts and a coincident load
        evt_in = 4'hF; dir_up = 4'hF;
        cyc(10);
        rst = 1'b1; load = 1'b1; load_mask = 4'hF; load_val = 16'h5555;
        cyc(1);
        rst = 1'b0; load = 1'b0;
        check("rst override counts", 64'(count_out), 64'h0);
        check("rst override flags", 64'(limit_flag), 64'h0);
        cyc(3);
        check("no tick before 4", 64'(count_out), 64'h0);
        cyc(1);
        check("tick after 4", 64'(count_out), 64'h0001_0001_0001_0001);

        // Mixed directed vectors checked by the model
        for (int i = 0; i < 6; i++) begin
            evt_in = vecs[i].evt; dir_up = vecs[i].dir; sat_mode = vecs[i].sat;
            clr_flags = vecs[i].clr;
            load = 1'b1; load_mask = vecs[i].mask; load_val = vecs[i].val;
            cyc(1);
            load = 1'b0;
            cyc(vecs[i].cycles);
        end
        set_idle();
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
